// File: rtl/axi_bresp_buffer_if.sv
// AXI write-response (B) channel bundle seen from both sides of the response buffer.
// The slave modport is the buffer's view. The master modport is the view of the environment that drives it.
interface axi_bresp_buffer_if #(
  parameter int unsigned ID_W = 4
);
  logic            s_BVALID;
  logic            s_BREADY;
  logic [1:0]      s_BRESP;
  logic [ID_W-1:0] s_BID;
  logic            m_BVALID;
  logic            m_BREADY;
  logic [1:0]      m_BRESP;
  logic [ID_W-1:0] m_BID;

  modport slave (
    input  s_BVALID, s_BRESP, s_BID, m_BREADY,
    output s_BREADY, m_BVALID, m_BRESP, m_BID
  );

  modport master (
    output s_BVALID, s_BRESP, s_BID, m_BREADY,
    input  s_BREADY, m_BVALID, m_BRESP, m_BID
  );
endinterface

// File: rtl/axi_bresp_buffer.sv
// DEPTH-entry FIFO for AXI B responses (BID + BRESP) with saturating error statistics
// and a capture of the most recent error response.
module axi_bresp_buffer #(
  parameter int unsigned ID_W  = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  axi_bresp_buffer_if.slave      bus,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       err_cnt,
  output logic                   err_flag,
  output logic [ID_W-1:0]        err_id,
  output logic [1:0]             err_resp,
  input  logic                   err_clr
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned ENT_W = ID_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_flag_q, err_flag_d;
  logic [ID_W-1:0]  err_id_q, err_id_d;
  logic [1:0]       err_resp_q, err_resp_d;

  logic             s_bready_c;
  logic             m_bvalid_c;
  logic             push_c;
  logic             pop_c;
  logic             err_push_c;
  logic [ENT_W-1:0] head_c;

  // Handshake flags come from the registered level only, so the two sides never touch combinationally.
  always_comb begin
    s_bready_c = (level_q < LVL_W'(DEPTH));
    m_bvalid_c = (level_q != '0);
    push_c     = bus.s_BVALID && s_bready_c;
    pop_c      = m_bvalid_c && bus.m_BREADY;
    err_push_c = push_c && bus.s_BRESP[1];
    // Storage is never reset, so the head is masked to read zero while the FIFO is empty.
    head_c     = m_bvalid_c ? mem_q[rd_ptr_q] : '0;
  end

  // FIFO storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
    if (push_c) begin
      mem_d[wr_ptr_q] = {bus.s_BID, bus.s_BRESP};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Error statistics: the clear is applied first so that an error pushed in the same cycle survives it.
  always_comb begin
    err_cnt_d  = err_clr ? '0 : err_cnt_q;
    err_flag_d = err_clr ? 1'b0 : err_flag_q;
    err_id_d   = err_clr ? '0 : err_id_q;
    err_resp_d = err_clr ? '0 : err_resp_q;
    if (err_push_c) begin
      err_cnt_d  = (err_cnt_d == CNT_MAX) ? err_cnt_d : err_cnt_d + CNT_W'(1);
      err_flag_d = 1'b1;
      err_id_d   = bus.s_BID;
      err_resp_d = bus.s_BRESP;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
      err_id_q   <= '0;
      err_resp_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
      err_id_q   <= err_id_d;
      err_resp_q <= err_resp_d;
    end
  end

  always_ff @(posedge ACLK) begin
    mem_q <= mem_d;
  end

  assign bus.s_BREADY = s_bready_c;
  assign bus.m_BVALID = m_bvalid_c;
  assign bus.m_BID    = head_c[ENT_W-1:2];
  assign bus.m_BRESP  = head_c[1:0];
  assign level        = level_q;
  assign err_cnt      = err_cnt_q;
  assign err_flag     = err_flag_q;
  assign err_id       = err_id_q;
  assign err_resp     = err_resp_q;

endmodule
